// File: rtl/spi_xfer_sequencer_if.sv
// Handshake/strobe bundle between the SPI register block, baud generator,
// shift register and the master transfer sequencer.
// master: requester side (register block / baud generator / bench)
// slave : the sequencer itself
interface spi_xfer_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic          spe;
  logic          mstr;
  logic          cpha;
  logic          spiswai;
  logic [1:0]    spimode;
  logic          start;
  logic          edge_lead;
  logic          edge_trail;
  logic          spif_clr;

  logic          start_ack;
  logic          ss;
  logic          baud_en;
  logic          load_tx;
  logic          shift_en;
  logic          sample_en;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          spif;

  modport master (
    output spe, mstr, cpha, spiswai, spimode, start, edge_lead, edge_trail, spif_clr,
    input  start_ack, ss, baud_en, load_tx, shift_en, sample_en, bit_cnt, busy, spif
  );

  modport slave (
    input  spe, mstr, cpha, spiswai, spimode, start, edge_lead, edge_trail, spif_clr,
    output start_ack, ss, baud_en, load_tx, shift_en, sample_en, bit_cnt, busy, spif
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Master-side SPI transfer sequencer: ss setup, bit framing from baud-generator
// edge flags, ss hold, sticky spif, wait/stop freeze and spe abort.
// Optional feature macro: SPI_BACK_TO_BACK_EN (one-deep start latch, frames
// chained with ss held low).
//
// state | meaning
// IDLE  | ss high, waiting for an accepted start
// SETUP | ss low, timing ss-to-sclk setup
// XFER  | baud generator running, strobes follow edge flags
// HOLD  | sclk stopped, timing ss hold before release
module spi_xfer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2
) (
  input  logic pclk,
  input  logic preset,
  spi_xfer_sequencer_if.slave bus
);
  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam int TMAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ss_q, ss_d, baud_q, baud_d, spif_q, spif_d, busy_q, busy_d;
  logic          ack_q, ack_d, load_q, load_d, shift_q, shift_d, sample_q, sample_d;
  logic          frozen;
`ifdef SPI_BACK_TO_BACK_EN
  logic          pend_q, pend_d;
`endif

  assign frozen  = (bus.spiswai & (bus.spimode == 2'b01)) | bus.spimode[1];
  assign cnt_inc = cnt_q + CW'(1);

  // State and all outputs are registered; async reset forces the idle/safe levels.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      cnt_q    <= '0;
      ss_q     <= 1'b1;
      baud_q   <= 1'b0;
      spif_q   <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
`ifdef SPI_BACK_TO_BACK_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      cnt_q    <= cnt_d;
      ss_q     <= ss_d;
      baud_q   <= baud_d;
      spif_q   <= spif_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
`ifdef SPI_BACK_TO_BACK_EN
      pend_q   <= pend_d;
`endif
    end
  end

  // Next-state and next-output decode; spe=0 overrides everything except spif.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    ss_d     = ss_q;
    baud_d   = baud_q;
    spif_d   = spif_q & ~bus.spif_clr;
    ack_d    = 1'b0;
    load_d   = 1'b0;
    shift_d  = 1'b0;
    sample_d = 1'b0;
`ifdef SPI_BACK_TO_BACK_EN
    pend_d   = pend_q;
    if ((state_q == XFER || state_q == HOLD) && bus.start && bus.mstr)
      pend_d = 1'b1;
`endif
    if (!bus.spe) begin
      state_d = IDLE;
      ss_d    = 1'b1;
      baud_d  = 1'b0;
      cnt_d   = '0;
`ifdef SPI_BACK_TO_BACK_EN
      pend_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && bus.mstr && !frozen) begin
            ack_d   = 1'b1;
            load_d  = 1'b1;
            ss_d    = 1'b0;
            tmr_d   = TW'(SS_SETUP - 1);
            state_d = SETUP;
          end
        end
        SETUP: begin
          if (!frozen) begin
            if (tmr_q == '0) begin
              baud_d  = 1'b1;
              cnt_d   = '0;
              state_d = XFER;
            end else begin
              tmr_d = tmr_q - TW'(1);
            end
          end
        end
        XFER: begin
          if (frozen) begin
            baud_d = 1'b0;
          end else begin
            baud_d = 1'b1;
            if (bus.edge_lead) begin
              if (bus.cpha) shift_d  = 1'b1;
              else          sample_d = 1'b1;
            end
            if (bus.edge_trail) begin
              cnt_d = cnt_inc;
              // cpha=0 has no shift after the final trailing edge: the frame is done
              if (bus.cpha)                          sample_d = 1'b1;
              else if (cnt_inc != CW'(DATA_WIDTH))   shift_d  = 1'b1;
              if (cnt_inc == CW'(DATA_WIDTH)) begin
                baud_d  = 1'b0;
                tmr_d   = TW'(SS_HOLD - 1);
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!frozen) begin
            if (tmr_q == '0) begin
              spif_d = 1'b1;
`ifdef SPI_BACK_TO_BACK_EN
              if (pend_q || (bus.start && bus.mstr)) begin
                ack_d   = 1'b1;
                load_d  = 1'b1;
                pend_d  = 1'b0;
                tmr_d   = TW'(SS_SETUP - 1);
                state_d = SETUP;
              end else begin
                ss_d    = 1'b1;
                state_d = IDLE;
              end
`else
              ss_d    = 1'b1;
              state_d = IDLE;
`endif
            end else begin
              tmr_d = tmr_q - TW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign bus.start_ack = ack_q;
  assign bus.ss        = ss_q;
  assign bus.baud_en   = baud_q;
  assign bus.load_tx   = load_q;
  assign bus.shift_en  = shift_q;
  assign bus.sample_en = sample_q;
  assign bus.bit_cnt   = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.spif      = spif_q;
endmodule
